// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: clears the RAM after reset, then runs push/pop traffic.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module dpram_fifo_ctrl #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              init_done,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_dout_b
`ifdef FIFO_ERR_FLAGS_EN
   ,output logic              ovf,
    output logic              udf
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // state   | meaning
    // ST_INIT | clearing RAM one address per cycle, traffic ignored
    // ST_RUN  | normal FIFO operation
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              init_done_q, init_done_d;
    logic              push_acc;
    logic              pop_acc;
`ifdef FIFO_ERR_FLAGS_EN
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
`endif

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_dout_b;
    assign init_done = init_done_q;
`ifdef FIFO_ERR_FLAGS_EN
    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        init_done_d = init_done_q;
        rd_valid_d  = 1'b0;
        push_acc    = 1'b0;
        pop_acc     = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_addr_a  = wr_ptr_q;
        ram_data_a  = wr_data;
        ram_addr_b  = rd_ptr_q;
`ifdef FIFO_ERR_FLAGS_EN
        ovf_d       = ovf_q;
        udf_d       = udf_q;
`endif
        case (state_q)
            ST_INIT: begin
                ram_cs     = 1'b1;
                ram_we     = 1'b1;
                ram_addr_a = init_cnt_q;
                ram_data_a = '0;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
                pop_acc  = rd_en && !empty;
                push_acc = wr_en && (!full || pop_acc);
                if (push_acc) begin
                    ram_cs   = 1'b1;
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
                if (pop_acc) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
                rd_valid_d = pop_acc;
                case ({push_acc, pop_acc})
                    2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                    2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                    default: count_d = count_q;
                endcase
`ifdef FIFO_ERR_FLAGS_EN
                if (wr_en && !push_acc) ovf_d = 1'b1;
                if (rd_en && !pop_acc)  udf_d = 1'b1;
`endif
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            init_done_q <= init_done_d;
`ifdef FIFO_ERR_FLAGS_EN
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
`endif
        end
    end

endmodule
